// File: rtl/sdram_sample_loader.sv
// sdram_sample_loader: Avalon-MM read master that copies NUM_SAMPLES samples
// from SDRAM into the sample SRAM, then pulses fft_start / load_done.
//
// state | meaning
// IDLE  | waiting for load_start; outputs quiet
// ISSUE | issuing pipelined reads, up to MAX_OUTSTANDING in flight
// DRAIN | all reads issued, collecting the remaining beats
// DONE  | one-cycle load_done / fft_start pulse
module sdram_sample_loader #(
  parameter int MASTER_ADDRESSWIDTH = 32,
  parameter int DATAWIDTH           = 32,
  parameter int SRAM_ADDRWIDTH      = 9,
  parameter int SRAM_DATAWIDTH      = 16,
  parameter int NUM_SAMPLES         = 512,
  parameter int ADDR_STRIDE         = 2,
  parameter int MAX_OUTSTANDING     = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           load_start,
  input  logic [MASTER_ADDRESSWIDTH-1:0] load_base,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic                           master_read,
  input  logic [DATAWIDTH-1:0]           master_readdata,
  input  logic                           master_readdatavalid,
  input  logic                           master_waitrequest,
  output logic                           sram_write_ena,
  output logic [SRAM_ADDRWIDTH-1:0]      sram_address,
  output logic [SRAM_DATAWIDTH-1:0]      sram_write_data,
  output logic                           load_busy,
  output logic                           load_done,
  output logic                           fft_start,
  output logic                           load_error
);

  localparam int MAW = MASTER_ADDRESSWIDTH;
  localparam int CW  = $clog2(NUM_SAMPLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [MAW-1:0]  addr_q, addr_d;
  logic [CW-1:0]   issued_q, issued_d;
  logic [CW-1:0]   received_q, received_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic            error_q, error_d;

  logic                      wr_ena_q;
  logic [SRAM_ADDRWIDTH-1:0] wr_addr_q;
  logic [SRAM_DATAWIDTH-1:0] wr_data_q;

  logic accept;
  logic good_beat;
  logic unused_rdata_hi;

  // Only the low sample bits of each beat are stored.
  assign unused_rdata_hi = ^master_readdata[DATAWIDTH-1:SRAM_DATAWIDTH];

  // Read request depends only on registered state, so it holds steady through waitrequest.
  assign master_read    = (state_q == S_ISSUE) && (outstanding_q < CW'(MAX_OUTSTANDING));
  assign master_address = addr_q;
  assign accept         = master_read && !master_waitrequest;
  // A beat is only legitimate when a read is actually in flight during a load.
  assign good_beat      = master_readdatavalid && (outstanding_q != '0) &&
                          ((state_q == S_ISSUE) || (state_q == S_DRAIN));

  assign load_busy       = (state_q != S_IDLE);
  assign load_done       = (state_q == S_DONE);
  assign fft_start       = (state_q == S_DONE);
  assign load_error      = error_q;
  assign sram_write_ena  = wr_ena_q;
  assign sram_address    = wr_addr_q;
  assign sram_write_data = wr_data_q;

  // State and counter registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      outstanding_q <= outstanding_d;
      error_q       <= error_d;
    end
  end

  // Next-state, address and counter logic.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    issued_d      = issued_q;
    received_d    = received_q;
    error_d       = error_q;
    // Accept and beat in the same cycle cancel out.
    outstanding_d = outstanding_q + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, good_beat};
    if (good_beat) begin
      received_d = received_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          addr_d        = load_base;
          issued_d      = '0;
          received_d    = '0;
          outstanding_d = '0;
          error_d       = 1'b0;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          addr_d   = addr_q + MAW'(ADDR_STRIDE);
          issued_d = issued_q + 1'b1;
          if (issued_q == CW'(NUM_SAMPLES - 1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // received_q reaches the total one cycle after the last beat, i.e. while
        // the final SRAM write is being driven.
        if (received_q == CW'(NUM_SAMPLES)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A spurious beat flags an error even if it coincides with a new start.
    if (master_readdatavalid && !good_beat) begin
      error_d = 1'b1;
    end
  end

  // Registered SRAM write port, one cycle behind each good beat.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ena_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_ena_q <= good_beat;
      if (good_beat) begin
        wr_addr_q <= SRAM_ADDRWIDTH'(received_q);
        wr_data_q <= master_readdata[SRAM_DATAWIDTH-1:0];
      end
    end
  end

endmodule
